// File: rtl/id_hazard_scheduler_pkg.sv
// rtl/id_hazard_scheduler_pkg.sv - shared types for the ID hazard scheduler
package id_hazard_scheduler_pkg;

    localparam int LC3B_REG_W = 3;

    typedef logic [LC3B_REG_W-1:0] lc3b_reg;

    // 0 selects the regfile read, 1 selects the WB write data
    typedef logic lc3b_forward_ID_mux_sel;

    typedef struct packed {
        logic    valid;
        logic    load_reg;
        lc3b_reg dest;
    } lc3b_hazard_slot;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_RAW,
        HZ_FROZEN
    } lc3b_hazard_state;

    function automatic logic slot_match(input lc3b_hazard_slot s, input lc3b_reg r);
        return s.valid & s.load_reg & (s.dest == r);
    endfunction

endpackage

// File: rtl/id_hazard_scheduler_if.sv
// rtl/id_hazard_scheduler_if.sv - decode-side signals between ID and the hazard scheduler
interface id_hazard_scheduler_if #(
    parameter int CNT_W = 16
);
    import id_hazard_scheduler_pkg::*;

    logic                   id_valid;
    lc3b_reg                id_sr1;
    lc3b_reg                id_sr2;
    logic                   id_sr1_used;
    logic                   id_sr2_used;
    lc3b_reg                id_dest;
    logic                   id_load_reg;
    logic                   mem_stall;
    lc3b_forward_ID_mux_sel forward_ID_A_mux_sel;
    lc3b_forward_ID_mux_sel forward_ID_B_mux_sel;
    logic                   stall_front;
    logic                   bubble_ex;
    logic [CNT_W-1:0]       raw_stall_count;

    modport master (
        output id_valid, id_sr1, id_sr2, id_sr1_used, id_sr2_used,
               id_dest, id_load_reg, mem_stall,
        input  forward_ID_A_mux_sel, forward_ID_B_mux_sel,
               stall_front, bubble_ex, raw_stall_count
    );

    modport slave (
        input  id_valid, id_sr1, id_sr2, id_sr1_used, id_sr2_used,
               id_dest, id_load_reg, mem_stall,
        output forward_ID_A_mux_sel, forward_ID_B_mux_sel,
               stall_front, bubble_ex, raw_stall_count
    );

endinterface

// File: rtl/id_hazard_scheduler_scoreboard.sv
// rtl/id_hazard_scheduler_scoreboard.sv - EX/MEM/WB shadow slots with RAW and forward match logic
module id_hazard_scheduler_scoreboard
    import id_hazard_scheduler_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_hold,
    input  logic                   i_id_valid,
    input  lc3b_reg                i_id_sr1,
    input  lc3b_reg                i_id_sr2,
    input  logic                   i_id_sr1_used,
    input  logic                   i_id_sr2_used,
    input  lc3b_reg                i_id_dest,
    input  logic                   i_id_load_reg,
    output logic                   o_raw,
    output lc3b_forward_ID_mux_sel o_fwd_a,
    output lc3b_forward_ID_mux_sel o_fwd_b
);

    lc3b_hazard_slot r_ex;
    lc3b_hazard_slot r_mem;
    lc3b_hazard_slot r_wb;

    logic            w_raw_a;
    logic            w_raw_b;
    logic            w_raw;
    lc3b_hazard_slot w_id_slot;

    // Only EX and MEM producers stall; a WB producer is covered by the forward path
    assign w_raw_a = i_id_sr1_used & (slot_match(r_ex, i_id_sr1) | slot_match(r_mem, i_id_sr1));
    assign w_raw_b = i_id_sr2_used & (slot_match(r_ex, i_id_sr2) | slot_match(r_mem, i_id_sr2));
    assign w_raw   = i_id_valid & (w_raw_a | w_raw_b);

    assign o_raw   = w_raw;
    assign o_fwd_a = i_id_valid & i_id_sr1_used & slot_match(r_wb, i_id_sr1) & ~w_raw;
    assign o_fwd_b = i_id_valid & i_id_sr2_used & slot_match(r_wb, i_id_sr2) & ~w_raw;

    assign w_id_slot.valid    = i_id_valid;
    assign w_id_slot.load_reg = i_id_load_reg;
    assign w_id_slot.dest     = i_id_dest;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!i_hold) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_raw ? '0 : w_id_slot;
        end
    end

endmodule

// File: rtl/id_hazard_scheduler.sv
// rtl/id_hazard_scheduler.sv - decode-stage RAW stall/bubble sequencing and WB->ID forward selects
module id_hazard_scheduler
    import id_hazard_scheduler_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    id_hazard_scheduler_if.slave bus
);

    logic                   w_raw;
    lc3b_forward_ID_mux_sel w_fwd_a;
    lc3b_forward_ID_mux_sel w_fwd_b;
    lc3b_hazard_state       r_state;
    logic [CNT_W-1:0]       r_raw_cnt;

    id_hazard_scheduler_scoreboard u_scoreboard (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_hold        (bus.mem_stall),
        .i_id_valid    (bus.id_valid),
        .i_id_sr1      (bus.id_sr1),
        .i_id_sr2      (bus.id_sr2),
        .i_id_sr1_used (bus.id_sr1_used),
        .i_id_sr2_used (bus.id_sr2_used),
        .i_id_dest     (bus.id_dest),
        .i_id_load_reg (bus.id_load_reg),
        .o_raw         (w_raw),
        .o_fwd_a       (w_fwd_a),
        .o_fwd_b       (w_fwd_b)
    );

    // A frozen pipeline must not lose the stalled instruction, so freeze suppresses the bubble
    assign bus.stall_front          = w_raw | bus.mem_stall;
    assign bus.bubble_ex            = w_raw & ~bus.mem_stall;
    assign bus.forward_ID_A_mux_sel = w_fwd_a;
    assign bus.forward_ID_B_mux_sel = w_fwd_b;
    assign bus.raw_stall_count      = r_raw_cnt;

    // State only feeds the performance counter; it lags raw by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= HZ_RUN;
            r_raw_cnt <= '0;
        end else begin
            if (r_state == HZ_RAW && !bus.mem_stall && r_raw_cnt != '1) begin
                r_raw_cnt <= r_raw_cnt + CNT_W'(1);
            end
            case (r_state)
                HZ_RUN: begin
                    if (bus.mem_stall)   r_state <= HZ_FROZEN;
                    else if (w_raw)      r_state <= HZ_RAW;
                end
                HZ_RAW: begin
                    if (bus.mem_stall)   r_state <= HZ_FROZEN;
                    else if (!w_raw)     r_state <= HZ_RUN;
                end
                HZ_FROZEN: begin
                    if (!bus.mem_stall)  r_state <= w_raw ? HZ_RAW : HZ_RUN;
                end
                default:                 r_state <= HZ_RUN;
            endcase
        end
    end

endmodule
